nanov_fetch_seq: RTL

//  Instruction sequencer/fetch stage directly upstream of the nanoV core. Streams instructions
//  bit-serially from SPI flash (READ 0x03), assembles them little-endian, and drives the core's

---
 rtl/nanov_fetch_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/nanov_fetch_seq.sv
// ============================================================================
// Module   : nanov_fetch_seq
// Brief    : Bit-serial SPI-flash instruction fetch/sequencer feeding nanoV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nanov_fetch_seq #(
  parameter int          PC_BITS    = 22,
  parameter logic [23:0] RESET_ADDR = 24'h000000,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        branch,
  input  logic        shift_pc,
  input  logic [31:0] data_out,
  output logic [31:0] instr,
  output logic [30:0] next_instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        pc,
  output logic        spi_select,
  output logic        spi_clk_en,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [PC_BITS-1:0] PC_RESET = PC_BITS'(RESET_ADDR);
  localparam logic [7:0]         SPI_READ = 8'h03;

  state_t               state_q, state_d;
  logic [4:0]           counter_q, counter_d;
  logic [2:0]           cycle_q, cycle_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          word_q, word_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic                 taken_q, taken_d;

  logic                 last;
  logic [2:0]           ncyc;
  logic                 final_cyc;
  logic                 fetching;
  logic [4:0]           bit_idx;
  logic [31:0]          word_next;
  logic [23:0]          fetch_addr;
  logic [31:0]          cmd_word;

  function automatic logic [2:0] ncyc_of(input logic [6:0] op, input logic [1:0] f3_lo);
    logic [2:0] n;
    n = 3'd1;
    case (op)
      7'b1101111, 7'b1100111: n = 3'd2;
      7'b1100011:             n = 3'd2;
      7'b0000011:             n = 3'd3;
      7'b0100011:             n = 3'd2;
      7'b0010011, 7'b0110011: n = (f3_lo == 2'b01) ? 3'd2 : 3'd1;
      default:                n = 3'd1;
    endcase
    return n;
  endfunction

  assign last      = (counter_q == 5'd31);
  assign ncyc      = ncyc_of(instr_q[6:0], instr_q[13:12]);
  assign final_cyc = (cycle_q == (ncyc - 3'd1));
  assign fetching  = (state_q == ST_FILL) || ((state_q == ST_RUN) && final_cyc);

  // Flash streams each byte MSB first; bytes land little-endian.
  assign bit_idx = {counter_q[4:3], ~counter_q[2:0]};

  always_comb begin
    word_next          = (counter_q == 5'd0) ? 32'd0 : word_q;
    word_next[bit_idx] = spi_miso;
  end

  assign fetch_addr = 24'(pc_q) & 24'hFFFFFC;
  assign cmd_word   = {SPI_READ, fetch_addr};

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q + 5'd1;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    word_d    = word_q;
    pc_d      = pc_q;
    taken_d   = taken_q;

    if (fetching) begin
      word_d = word_next;
    end

    if (shift_pc) begin
      pc_d = {pc_q[0], pc_q[PC_BITS-1:1]};
    end

    unique case (state_q)
      ST_IDLE: begin
        cycle_d = 3'd0;
        taken_d = 1'b0;
        if (last) state_d = ST_CMD;
      end
      ST_CMD: begin
        cycle_d = 3'd0;
        taken_d = 1'b0;
        if (last) state_d = ST_FILL;
      end
      ST_FILL: begin
        cycle_d = 3'd0;
        taken_d = 1'b0;
        if (last) begin
          state_d = ST_RUN;
          instr_d = word_next;
        end
      end
      ST_RUN: begin
        if (branch) taken_d = 1'b1;
        if (last) begin
          if (final_cyc) begin
            cycle_d = 3'd0;
            taken_d = 1'b0;
            // A branch on the end clock itself still redirects.
            if (taken_q || branch) begin
              pc_d    = data_out[PC_BITS-1:0];
              state_d = ST_IDLE;
              instr_d = NOP;
            end else begin
              pc_d    = pc_q + PC_BITS'(4);
              instr_d = word_next;
            end
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      counter_q <= 5'd0;
      cycle_q   <= 3'd0;
      instr_q   <= NOP;
      word_q    <= 32'd0;
      pc_q      <= PC_RESET;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      word_q    <= word_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
    end
  end

  generate
    if (PC_BITS < 32) begin : g_unused_hi
      logic unused_data_hi;
      assign unused_data_hi = ^data_out[31:PC_BITS];
    end
  endgenerate

  assign instr      = instr_q;
  assign next_instr = fetching ? word_next[30:0] : 31'd0;
  assign cycle      = cycle_q;
  assign counter    = counter_q;
  assign pc         = pc_q[0];
  assign spi_select = (state_q == ST_IDLE);
  assign spi_clk_en = (state_q == ST_CMD) || fetching;
  assign spi_mosi   = (state_q == ST_CMD) ? cmd_word[~counter_q] : 1'b0;

endmodule

`default_nettype wire
